// File: rtl/hs_sync_fifo_pkg.sv
// hs_sync_fifo_pkg: shared defaults, pointer sizing and handshake op encoding
package hs_sync_fifo_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem: dual-port register array, synchronous write, asynchronous read
module hs_fifo_mem import hs_sync_fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: first-word-fall-through valid/ready FIFO with flags derived from registered count
module hs_sync_fifo import hs_sync_fifo_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    full
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  op_e           op;
  assign empty       = count == '0;
  assign full        = count == CW'(DEPTH);
  assign almost_full = count >= CW'(AF_LEVEL);
  assign s_ready     = !full && !rst;
  assign m_valid     = !empty;
  assign push        = s_valid && s_ready;
  assign pop         = m_valid && m_ready;
  assign op          = op_e'({push, pop});
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= (op == OP_PUSH) ? count + CW'(1) : (op == OP_POP) ? count - CW'(1) : count;
    end
  end
  hs_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (m_data)
  );
endmodule

// File: tb/tb_hs_sync_fifo.sv
// tb_hs_sync_fifo: directed and random stimulus checked against a queue reference model
module tb_hs_sync_fifo;
  localparam int W = 8, D = 4, AF = 3;
  logic clk = 0, rst = 1, s_valid = 0, m_ready = 0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, almost_full, empty, full;
  logic [W-1:0] m_data;
  logic [2:0] count;
  int vec = 0, err = 0;
  logic [W-1:0] q[$], ins[$], outs[$];
  bit armed = 0, pushed = 0, prev_hold = 0;
  logic [W-1:0] prev_data;

  hs_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .almost_full(almost_full), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Checks outputs mid-cycle against the queue, then advances the model across one edge.
  task automatic cycle();
    bit ep, epush, epop;
    #4;
    ep = !rst && q.size() < D;
    if (armed) begin
      check("s_ready", s_ready, ep);
      check("m_valid", m_valid, q.size() > 0);
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == D);
      check("almost_full", almost_full, q.size() >= AF);
      if (q.size() > 0) check("m_data", m_data, q[0]);
      if (prev_hold) check("hold_stable", m_data, prev_data);
      if (m_valid && m_ready && !rst) outs.push_back(m_data);
    end
    prev_hold = armed && m_valid && !m_ready && !rst;
    prev_data = m_data;
    epush = s_valid && ep;
    epop = m_ready && q.size() > 0 && !rst;
    @(posedge clk);
    pushed = 0;
    if (rst) q.delete();
    else begin
      if (epop) void'(q.pop_front());
      if (epush) begin
        q.push_back(s_data);
        ins.push_back(s_data);
        pushed = 1;
      end
    end
    armed = 1;
    #1;
  endtask

  initial begin
    int n, budget;
    rst = 1; s_valid = 1; s_data = 8'hAA;
    repeat (2) cycle();
    rst = 0; s_valid = 0;
    cycle();
    check("no_beat_from_reset", outs.size(), 0);

    m_ready = 0; s_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      s_data = W'(i);
      cycle();
    end
    s_data = 8'h05;
    cycle();
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (pushed) s_valid = 0;
    end
    check("drain_len", outs.size(), 5);
    for (int i = 0; i < 5; i++) check("drain_data", i < outs.size() ? 32'(outs[i]) : 32'hx, i + 1);

    outs.delete();
    s_valid = 1; m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      s_data = W'(8'h10 + i);
      cycle();
    end
    s_valid = 0;
    repeat (3) cycle();
    check("stream_len", outs.size(), 20);
    for (int i = 0; i < 20; i++) check("stream_data", i < outs.size() ? 32'(outs[i]) : 32'hx, 8'h10 + i);

    outs.delete(); ins.delete();
    n = 0; budget = 0;
    while (n < 1000 && budget < 20000) begin
      s_valid = 1'($urandom);
      s_data = W'($urandom);
      m_ready = 1'($urandom);
      cycle();
      n += int'(pushed);
      budget++;
    end
    s_valid = 0; m_ready = 1;
    repeat (D + 2) cycle();
    check("rand_pushes", n, 1000);
    check("rand_len", outs.size(), ins.size());
    for (int i = 0; i < ins.size(); i++) check("rand_data", i < outs.size() ? 32'(outs[i]) : 32'hx, ins[i]);

    outs.delete();
    m_ready = 0; s_valid = 1;
    repeat (3) begin
      s_data = W'($urandom);
      cycle();
    end
    s_data = 8'hEE; rst = 1;
    cycle();
    rst = 0; s_data = 8'h5A;
    cycle();
    s_valid = 0; m_ready = 1;
    repeat (3) cycle();
    check("post_rst_len", outs.size(), 1);
    check("post_rst_first", outs.size() > 0 ? 32'(outs[0]) : 32'hx, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
